// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480@60 VGA timing generator that scans the Tron arena
// framebuffer through a read-only memory port and drives palette-mapped RGB.
module vga_fb_reader #(
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'(8192),
   parameter int unsigned           GRID_W     = 80,
   parameter int unsigned           CELL_SHIFT = 3,
   parameter int unsigned           CLK_DIV    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   input  logic [DATA_WIDTH-1:0] fb_data,
   output logic                  hsync,
   output logic                  vsync,
   output logic [7:0]            red,
   output logic [7:0]            green,
   output logic [7:0]            blue,
   output logic                  vblank,
   output logic                  frame_tick
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   localparam logic [9:0] H_VISIBLE    = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd751;
   localparam logic [9:0] H_LAST       = 10'd799;
   localparam logic [9:0] V_VISIBLE    = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd491;
   localparam logic [9:0] V_LAST       = 10'd524;

   logic [DIV_W-1:0]      divCnt_q, divCnt_d;
   logic [9:0]            hCnt_q, hCnt_d;
   logic [9:0]            vCnt_q, vCnt_d;
   logic [ADDR_WIDTH-1:0] fbAddr_q, fbAddr_d;
   logic                  vis1_q, vis1_d;
   logic                  hs1_q, hs1_d;
   logic                  vs1_q, vs1_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic [7:0]            red_q, red_d;
   logic [7:0]            green_q, green_d;
   logic [7:0]            blue_q, blue_d;
   logic                  frameTick_q, frameTick_d;

   logic                  tick;
   logic                  visible;
   logic                  lineEnd;
   logic                  hSyncActive;
   logic                  vSyncActive;
   logic [ADDR_WIDTH-1:0] cellRow;
   logic [ADDR_WIDTH-1:0] cellCol;
   logic [ADDR_WIDTH-1:0] cellAddr;
   logic [23:0]           paletteRgb;
   logic                  unusedDataBits;

   assign tick        = (divCnt_q == DIV_W'(CLK_DIV - 1));
   assign visible     = (hCnt_q < H_VISIBLE) && (vCnt_q < V_VISIBLE);
   assign lineEnd     = (hCnt_q == H_LAST);
   assign hSyncActive = (hCnt_q >= H_SYNC_START) && (hCnt_q <= H_SYNC_END);
   assign vSyncActive = (vCnt_q >= V_SYNC_START) && (vCnt_q <= V_SYNC_END);

   // Cell address wraps modulo the address width by construction.
   assign cellRow  = ADDR_WIDTH'(vCnt_q >> CELL_SHIFT);
   assign cellCol  = ADDR_WIDTH'(hCnt_q >> CELL_SHIFT);
   assign cellAddr = FB_BASE + cellRow * ADDR_WIDTH'(GRID_W) + cellCol;

   assign unusedDataBits = ^fb_data[DATA_WIDTH-1:4];

   always_comb begin
      case (fb_data[3:0])
         4'd0:    paletteRgb = 24'h000000;
         4'd1:    paletteRgb = 24'h00FFFF;
         4'd2:    paletteRgb = 24'hFF8000;
         4'd3:    paletteRgb = 24'hFFFFFF;
         4'd4:    paletteRgb = 24'h000080;
         default: paletteRgb = 24'hFF00FF;
      endcase
   end

   // Stage A issues the read for the current counters; stage B consumes the
   // returned word one tick later together with the delayed syncs.
   always_comb begin
      divCnt_d    = tick ? '0 : divCnt_q + 1'b1;
      hCnt_d      = hCnt_q;
      vCnt_d      = vCnt_q;
      fbAddr_d    = fbAddr_q;
      vis1_d      = vis1_q;
      hs1_d       = hs1_q;
      vs1_d       = vs1_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      frameTick_d = 1'b0;
      if (tick) begin
         fbAddr_d = visible ? cellAddr : FB_BASE;
         vis1_d   = visible;
         hs1_d    = ~hSyncActive;
         vs1_d    = ~vSyncActive;
         hsync_d  = hs1_q;
         vsync_d  = vs1_q;
         {red_d, green_d, blue_d} = vis1_q ? paletteRgb : 24'h000000;
         frameTick_d = lineEnd && (vCnt_q == V_VISIBLE - 10'd1);
         if (lineEnd) begin
            hCnt_d = 10'd0;
            vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
         end else begin
            hCnt_d = hCnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         divCnt_q    <= '0;
         hCnt_q      <= 10'd0;
         vCnt_q      <= 10'd0;
         fbAddr_q    <= FB_BASE;
         vis1_q      <= 1'b0;
         hs1_q       <= 1'b1;
         vs1_q       <= 1'b1;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         red_q       <= 8'd0;
         green_q     <= 8'd0;
         blue_q      <= 8'd0;
         frameTick_q <= 1'b0;
      end else begin
         divCnt_q    <= divCnt_d;
         hCnt_q      <= hCnt_d;
         vCnt_q      <= vCnt_d;
         fbAddr_q    <= fbAddr_d;
         vis1_q      <= vis1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         frameTick_q <= frameTick_d;
      end
   end

   assign fb_addr    = fbAddr_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign red        = red_q;
   assign green      = green_q;
   assign blue       = blue_q;
   assign vblank     = (vCnt_q >= V_VISIBLE);
   assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: scoreboard bench for vga_fb_reader with a behavioural
// 1-clk-latency framebuffer RAM and a pixel-position reference model.
module tb_vga_fb_reader;

   localparam int CLK_DIV = 2;

   logic        clk;
   logic        rstN;
   logic [15:0] fb_addr;
   logic [15:0] fb_data;
   logic        hsync;
   logic        vsync;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        vblank;
   logic        frame_tick;

   logic [15:0] ram [0:65535];

   typedef struct {
      bit          vis;
      bit          hs;
      bit          vs;
      int          h;
      int          v;
      logic [15:0] addr;
   } stageRec_t;

   stageRec_t pipeQ[$];

   int mDiv, mH, mV;
   logic        eHs, eVs, eFrameTick, eVblank;
   logic [23:0] eRgb;
   logic [15:0] eAddr;

   int assertCnt = 0;
   int failCnt   = 0;
   int edgeCnt   = 0;

   bit prevHs, prevVs, firstHsPending;
   int lastHsFall  = -1;
   int tickEdge    = -1;
   int vsFallEdge  = -1;
   int ftCount     = 0;
   int vsRises     = 0;

   vga_fb_reader dut (
      .clk        (clk),
      .reset      (rstN),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .hsync      (hsync),
      .vsync      (vsync),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .vblank     (vblank),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) fb_data <= ram[fb_addr];

   function automatic logic [23:0] palette(input logic [3:0] idx);
      case (idx)
         4'd0:    return 24'h000000;
         4'd1:    return 24'h00FFFF;
         4'd2:    return 24'hFF8000;
         4'd3:    return 24'hFFFFFF;
         4'd4:    return 24'h000080;
         default: return 24'hFF00FF;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCnt++;
      assert (observed === expected) else begin
         failCnt++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus: update the reference model at the edge, then
   // compare every output on the following falling edge.
   task automatic applyStimulus();
      stageRec_t   prev, cur;
      bit          inReset, dirAddr, dirRgb;
      logic [15:0] dirAddrExp;
      logic [23:0] dirRgbExp;
      string       dirAddrTag, dirRgbTag;
      dirAddr = 0; dirRgb = 0; dirAddrExp = '0; dirRgbExp = '0;
      dirAddrTag = ""; dirRgbTag = "";
      @(posedge clk);
      inReset = !rstN;
      if (inReset) begin
         mDiv = 0; mH = 0; mV = 0; edgeCnt = 0;
         pipeQ.delete();
         pipeQ.push_back('{vis: 1'b0, hs: 1'b1, vs: 1'b1, h: 0, v: 0, addr: 16'd8192});
         eHs = 1'b1; eVs = 1'b1; eRgb = '0; eAddr = 16'd8192; eFrameTick = 1'b0;
      end else begin
         edgeCnt++;
         eFrameTick = 1'b0;
         if (mDiv == CLK_DIV - 1) begin
            mDiv = 0;
            prev = pipeQ.pop_front();
            eHs  = prev.hs;
            eVs  = prev.vs;
            eRgb = prev.vis ? palette(ram[prev.addr][3:0]) : 24'h000000;
            if (prev.vis && prev.v == 0 && prev.h < 8) begin
               dirRgb = 1; dirRgbExp = 24'h00FFFF; dirRgbTag = "rgb_line0_px0_7";
            end else if (prev.v == 0 && prev.h >= 632 && prev.h <= 639) begin
               dirRgb = 1; dirRgbExp = 24'hFF8000; dirRgbTag = "rgb_line0_px632_639";
            end else if (prev.v == 9 && prev.h == 17) begin
               dirRgb = 1; dirRgbExp = 24'hFF00FF; dirRgbTag = "rgb_index9";
            end else if (!prev.vis) begin
               dirRgb = 1; dirRgbExp = 24'h000000; dirRgbTag = "rgb_blank";
            end
            cur.vis  = (mH < 640) && (mV < 480);
            cur.hs   = !(mH >= 656 && mH <= 751);
            cur.vs   = !(mV >= 490 && mV <= 491);
            cur.h    = mH;
            cur.v    = mV;
            cur.addr = cur.vis ? 16'(8192 + (mV / 8) * 80 + (mH / 8)) : 16'd8192;
            pipeQ.push_back(cur);
            eAddr = cur.addr;
            if (mH == 17 && mV == 9) begin
               dirAddr = 1; dirAddrExp = 16'd8274; dirAddrTag = "addr_h17_v9";
            end else if (mH == 639 && mV == 479) begin
               dirAddr = 1; dirAddrExp = 16'd12991; dirAddrTag = "addr_h639_v479";
            end else if (mH == 700) begin
               dirAddr = 1; dirAddrExp = 16'd8192; dirAddrTag = "addr_h700_blank";
            end
            eFrameTick = (mH == 799 && mV == 479);
            if (mH == 799) begin
               mH = 0;
               mV = (mV == 524) ? 0 : mV + 1;
            end else begin
               mH++;
            end
         end else begin
            mDiv++;
         end
      end
      eVblank = (mV >= 480);
      @(negedge clk);
      checkOutput("fb_addr", 32'(fb_addr), 32'(eAddr));
      checkOutput("sync", {30'd0, hsync, vsync}, {30'd0, eHs, eVs});
      checkOutput("rgb", {8'd0, red, green, blue}, {8'd0, eRgb});
      checkOutput("frame_tick", 32'(frame_tick), 32'(eFrameTick));
      checkOutput("vblank", 32'(vblank), 32'(eVblank));
      if (dirAddr) checkOutput(dirAddrTag, 32'(fb_addr), 32'(dirAddrExp));
      if (dirRgb) checkOutput(dirRgbTag, {8'd0, red, green, blue}, {8'd0, dirRgbExp});
      if (inReset) begin
         prevHs = 1; prevVs = 1; firstHsPending = 1; lastHsFall = -1; vsFallEdge = -1;
      end else begin
         if (prevHs && !hsync) begin
            if (firstHsPending) checkOutput("hsync_first_fall", edgeCnt, 2 * 656 + 4);
            firstHsPending = 0;
            if (lastHsFall >= 0) checkOutput("hsync_period", edgeCnt - lastHsFall, 1600);
            lastHsFall = edgeCnt;
         end
         if (!prevHs && hsync && lastHsFall >= 0)
            checkOutput("hsync_low_width", edgeCnt - lastHsFall, 192);
         if (frame_tick) begin
            ftCount++;
            tickEdge = edgeCnt;
         end
         if (prevVs && !vsync) begin
            if (tickEdge >= 0)
               checkOutput("vsync_fall_after_tick", edgeCnt, tickEdge + 10 * 1600 + 4);
            vsFallEdge = edgeCnt;
         end
         if (!prevVs && vsync && vsFallEdge >= 0) begin
            vsRises++;
            checkOutput("vsync_low_width", edgeCnt - vsFallEdge, 3200);
         end
         prevHs = hsync;
         prevVs = vsync;
      end
   endtask

   task automatic runClocks(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
      ram[8192]  = 16'h0001;
      ram[8193]  = 16'h0003;
      ram[8194]  = 16'h0004;
      ram[8196]  = 16'h000F;
      ram[8197]  = 16'h0005;
      ram[8271]  = 16'hFFF2;
      ram[8274]  = 16'h0009;
      ram[12991] = 16'h0004;

      rstN = 1'b0;
      runClocks(5);
      rstN = 1'b1;
      $display("[TB] reset released, running first 11 lines");
      runClocks(11 * 1600 + 50);

      // Jump to row 200 and reset in the middle of a line.
      force dut.vCnt_q = 10'd200;
      mV = 200;
      #1 release dut.vCnt_q;
      for (int i = 0; i < 2000 && !(mH == 300 && mDiv == 0); i++) applyStimulus();
      checkOutput("reach_h300_v200", {mH == 300, mV == 200}, 2'b11);
      rstN = 1'b0;
      applyStimulus();
      checkOutput("rst_fb_addr", 32'(fb_addr), 32'd8192);
      checkOutput("rst_sync", {30'd0, hsync, vsync}, 32'd3);
      checkOutput("rst_rgb", {8'd0, red, green, blue}, 32'd0);
      checkOutput("rst_frame_tick", 32'(frame_tick), 32'd0);
      runClocks(4);
      rstN = 1'b1;
      runClocks(3300);

      // Jump near the bottom of the frame to cover vblank, frame_tick and vsync.
      force dut.vCnt_q = 10'd477;
      mV = 477;
      #1 release dut.vCnt_q;
      ftCount = 0;
      vsRises = 0;
      tickEdge = -1;
      runClocks(17 * 1600);
      checkOutput("frame_tick_count", ftCount, 1);
      checkOutput("vsync_pulses_seen", vsRises, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Generates 640x480@60 VGA timing and scans the Tron arena framebuffer held in the shared exmem memory.
- Reads the framebuffer through exmem port 2 (addr2 / dataOut2), which this block owns read-only; the write-enable for port 2 (we2) is tied low at the top level.
- Maps each 4-bit cell colour index to 8-bit RGB for the display DAC.
- Gives the CPU a frame-rate game tick (frame_tick) and a vblank status flag.

Parameters:
- ADDR_WIDTH, 16, width of fb_addr; matches the exmem address width.
- DATA_WIDTH, 16, width of fb_data; matches the exmem data width.
- FB_BASE, 16'd8192, word address of arena cell (0,0).
- GRID_W, 80, cells per arena row (640 / 8).
- CELL_SHIFT, 3, log2 of cell size in pixels (8x8 cells).
- CLK_DIV, 2, system clocks per pixel; must be >= 2.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous, active-low.
- fb_addr, output, ADDR_WIDTH, connects to exmem addr2.
- fb_data, input, DATA_WIDTH, connects to exmem dataOut2; registered read, 1-clk latency.
- hsync, output, 1, horizontal sync, active-low.
- vsync, output, 1, vertical sync, active-low.
- red, output, 8, pixel red.
- green, output, 8, pixel green.
- blue, output, 8, pixel blue.
- vblank, output, 1, high while v_cnt >= 480.
- frame_tick, output, 1, one-clk pulse at the start of vertical blank.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-low, and sampled on posedge clk.
- Reset values:
  - div = 0, h_cnt = 0, v_cnt = 0.
  - fb_addr = FB_BASE.
  - hsync = 1, vsync = 1.
  - red = green = blue = 0.
  - frame_tick = 0.
  - Pipeline registers (vis1, hs1, vs1) = 0 / 1 / 1.
- Reset mid-frame: every register returns to its reset value on the first edge with reset low. Timing restarts at (0,0) after release. No partial-line recovery.
- Pixel tick:
  - div counts 0..CLK_DIV-1 and wraps.
  - tick = (div == CLK_DIV-1).
  - The first tick is the CLK_DIV-th edge after reset release.
  - All state below advances only on tick edges, except frame_tick deassertion.
- Horizontal counter h_cnt, 0..799:
  - 0-639 visible, 640-655 front porch, 656-751 sync, 752-799 back porch.
  - Wraps 799 -> 0 and increments v_cnt.
- Vertical counter v_cnt, 0..524:
  - 0-479 visible, 480-489 front porch, 490-491 sync, 492-524 back porch.
  - Wraps 524 -> 0.
- Stage A (tick edge, using current h_cnt/v_cnt):
  - visible: fb_addr <= FB_BASE + (v_cnt>>CELL_SHIFT)*GRID_W + (h_cnt>>CELL_SHIFT), computed modulo 2^ADDR_WIDTH (wraps, no saturation).
  - blanking: fb_addr <= FB_BASE.
  - vis1 <= visible.
  - hs1 <= ~(656 <= h_cnt <= 751).
  - vs1 <= ~(490 <= v_cnt <= 491).
  - Counters advance.
- Memory: exmem presents ram[fb_addr] on fb_data one clk after fb_addr changes. This is valid before the next tick because CLK_DIV >= 2.
- Stage B (next tick edge):
  - hsync <= hs1, vsync <= vs1.
  - RGB <= vis1 ? palette(fb_data[3:0]) : 0.
  - fb_data[15:4] is ignored.
- Latency: output pixel and sync lag the counters by exactly 2 ticks. Sync and colour stay mutually aligned.
- Palette (index -> R,G,B):
  - 0 -> 0,0,0
  - 1 -> 0,255,255 (player 1 cyan)
  - 2 -> 255,128,0 (player 2 orange)
  - 3 -> 255,255,255 (wall)
  - 4 -> 0,0,128 (grid)
  - 5-15 -> 255,0,255 (error magenta)
- vblank: combinational from the v_cnt register; high for v_cnt 480..524.
- frame_tick: high for exactly one clk, on the tick edge where v_cnt changes 479 -> 480; low at all other times. Exactly once per 525 lines.

Test Plan:
1. Reset: hold reset low 5 clk mid-stream -> next edge hsync=1, vsync=1, RGB=0, fb_addr=8192, frame_tick=0; after release, first tick on clk edge 2.
2. Line timing: free-run -> hsync low for 192 clk (96 ticks), period 1600 clk; first falling edge 2 ticks after h_cnt reaches 656.
3. Frame timing: vsync low for 2 lines (3200 clk), period 840000 clk; frame_tick one clk wide, once per 840000 clk, coincident with vblank rising.
4. Addressing: at counter pixel (h=17, v=9) -> fb_addr = 8192 + 1*80 + 2 = 8274; at (639,479) -> 8192 + 59*80 + 79 = 12991; during h=700 -> 8192.
5. Pixel data, with a behavioural 1-clk-latency RAM:
   - word 8192 = 16'h0001 -> first 8 visible pixels of line 0 are (0,255,255).
   - word 8271 = 16'hFFF2 -> pixels 632-639 of line 0 are (255,128,0).
   - index 9 -> (255,0,255).
   - nonzero data during blanking -> RGB=0.
6. Mid-line reset at h_cnt=300, v_cnt=200 -> outputs go to reset values next edge; after release, line 0 restarts and the first hsync low occurs 2 ticks after h_cnt reaches 656.
